// File: rtl/fp_mul_dispatch_if.sv
// Command/response bus between a host and the FP multiplier dispatcher.
// Host side is master, dispatcher side is slave.
interface fp_mul_dispatch_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic [TAG_W-1:0] cmd_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_z;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_z, rsp_tag, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_z, rsp_tag, rsp_err
  );
endinterface

// File: rtl/fp_mul_dispatch.sv
// Front-end for the single-precision multiplier: sequences the a/b/z
// strobe/ack handshakes, tags results and resets a hung multiplier.
module fp_mul_dispatch #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  fp_mul_dispatch_if.slave    bus,
  output logic [31:0]         mul_a,
  output logic                mul_a_stb,
  input  logic                mul_a_ack,
  output logic [31:0]         mul_b,
  output logic                mul_b_stb,
  input  logic                mul_b_ack,
  input  logic [31:0]         mul_z,
  input  logic                mul_z_stb,
  output logic                mul_z_ack,
  output logic                mul_rst,
  output logic                busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND_A  = 3'd1,
    SEND_B  = 3'd2,
    WAIT_Z  = 3'd3,
    ACK_Z   = 3'd4,
    RST_MUL = 3'd5,
    RESP    = 3'd6
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
  localparam logic [31:0] QNAN     = 32'h7FC00000;

  state_t           st_q, st_d;
  logic             crdy_q, crdy_d;
  logic             rval_q, rval_d;
  logic [31:0]      rz_q, rz_d;
  logic [TAG_W-1:0] rtag_q, rtag_d;
  logic             rerr_q, rerr_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic             astb_q, astb_d;
  logic             bstb_q, bstb_d;
  logic             zack_q, zack_d;
  logic             mrst_q, mrst_d;
  logic             busy_q, busy_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [15:0]      cnt_q, cnt_d;

  // Next-state and next-output decode; every register defaults to hold.
  always_comb begin
    st_d   = st_q;
    crdy_d = crdy_q;
    rval_d = rval_q;
    rz_d   = rz_q;
    rtag_d = rtag_q;
    rerr_d = rerr_q;
    a_d    = a_q;
    b_d    = b_q;
    astb_d = astb_q;
    bstb_d = bstb_q;
    zack_d = zack_q;
    mrst_d = mrst_q;
    tag_d  = tag_q;
    cnt_d  = cnt_q;
    unique case (st_q)
      IDLE: begin
        if (bus.cmd_valid && crdy_q) begin
          a_d    = bus.cmd_a;
          b_d    = bus.cmd_b;
          tag_d  = bus.cmd_tag;
          crdy_d = 1'b0;
          astb_d = 1'b1;
          st_d   = SEND_A;
        end
      end
      SEND_A: begin
        if (mul_a_ack) begin
          astb_d = 1'b0;
          bstb_d = 1'b1;
          st_d   = SEND_B;
        end
      end
      SEND_B: begin
        if (mul_b_ack) begin
          bstb_d = 1'b0;
          cnt_d  = '0;
          st_d   = WAIT_Z;
        end
      end
      WAIT_Z: begin
        if (mul_z_stb) begin
          rz_d   = mul_z;
          zack_d = 1'b1;
          st_d   = ACK_Z;
        end else if (cnt_q == CNT_LAST) begin
          mrst_d = 1'b1;
          rz_d   = QNAN;
          rerr_d = 1'b1;
          st_d   = RST_MUL;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ACK_Z: begin
        zack_d = 1'b0;
        rval_d = 1'b1;
        rtag_d = tag_q;
        rerr_d = 1'b0;
        st_d   = RESP;
      end
      RST_MUL: begin
        mrst_d = 1'b0;
        rval_d = 1'b1;
        rtag_d = tag_q;
        st_d   = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rval_d = 1'b0;
          crdy_d = 1'b1;
          st_d   = IDLE;
        end
      end
      default: begin
        st_d   = IDLE;
        crdy_d = 1'b1;
        rval_d = 1'b0;
        rz_d   = '0;
        rtag_d = '0;
        rerr_d = 1'b0;
        a_d    = '0;
        b_d    = '0;
        astb_d = 1'b0;
        bstb_d = 1'b0;
        zack_d = 1'b0;
        mrst_d = 1'b0;
        tag_d  = '0;
        cnt_d  = '0;
      end
    endcase
    busy_d = (st_d != IDLE);
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      crdy_q <= 1'b1;
      rval_q <= 1'b0;
      rz_q   <= '0;
      rtag_q <= '0;
      rerr_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      astb_q <= 1'b0;
      bstb_q <= 1'b0;
      zack_q <= 1'b0;
      mrst_q <= 1'b0;
      busy_q <= 1'b0;
      tag_q  <= '0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      crdy_q <= crdy_d;
      rval_q <= rval_d;
      rz_q   <= rz_d;
      rtag_q <= rtag_d;
      rerr_q <= rerr_d;
      a_q    <= a_d;
      b_q    <= b_d;
      astb_q <= astb_d;
      bstb_q <= bstb_d;
      zack_q <= zack_d;
      mrst_q <= mrst_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.cmd_ready = crdy_q;
  assign bus.rsp_valid = rval_q;
  assign bus.rsp_z     = rz_q;
  assign bus.rsp_tag   = rtag_q;
  assign bus.rsp_err   = rerr_q;
  assign mul_a         = a_q;
  assign mul_b         = b_q;
  assign mul_a_stb     = astb_q;
  assign mul_b_stb     = bstb_q;
  assign mul_z_ack     = zack_q;
  assign mul_rst       = mrst_q;
  assign busy          = busy_q;

endmodule
